store_buffer: RTL

- Word-granular FIFO write buffer between the MEM-stage control and the data memory.
- Absorbs store bursts so that stores never stall the pipeline unless the buffer is full.
- Drains buffered stores to the memory's single address port in idle MEM cycles.
- Forwards buffered data to loads that hit a pending store. Otherwise it passes loads straight through to memory with zero added latency.

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_match.sv | 41 ++++
 rtl/store_buffer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_buffer_pkg : shared sizing constants and entry layout for store_buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package store_buffer_pkg;

  localparam int SB_DEPTH     = 4;
  localparam int SB_ADDR_BITS = 14;
  localparam int SB_DATA_BITS = 32;
  localparam int SB_ENTRY_W   = SB_ADDR_BITS + SB_DATA_BITS;
  localparam int SB_PTR_W     = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_BITS-1:0] addr;
    logic [SB_DATA_BITS-1:0] data;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_match.sv
// ---------------------------------------------------------------------------
// store_buffer_match : finds the youngest valid entry whose address matches a load
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = SB_DEPTH,
  parameter int ADDR_BITS = SB_ADDR_BITS
) (
  input  logic [DEPTH-1:0][ADDR_BITS-1:0] i_ent_addr,
  input  logic [DEPTH-1:0]                i_valid,
  input  logic [$clog2(DEPTH)-1:0]        i_tail,
  input  logic [ADDR_BITS-1:0]            i_ld_addr,
  output logic                            o_hit,
  output logic [$clog2(DEPTH)-1:0]        o_idx
);

  localparam int PTR_W = sb_ptr_w(DEPTH);

  logic [PTR_W-1:0] w_slot;

  // Scan from oldest (slot at tail) to youngest (tail-1); the last match wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = i_tail + PTR_W'(k);
      if (i_valid[w_slot] && (i_ent_addr[w_slot] == i_ld_addr)) begin
        o_hit = 1'b1;
        o_idx = w_slot;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer : word-granular FIFO write buffer with load forwarding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = SB_DEPTH,
  parameter int ADDR_BITS = SB_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_req,
  input  logic                     ld_req,
  input  logic [31:0]              addr,
  input  logic [31:0]              wr_data,
  output logic [31:0]              ld_data,
  output logic                     stall,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [31:0]              mem_address,
  output logic [31:0]              mem_data,
  input  logic [31:0]              mem_out,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = sb_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                r_head;
  logic [PTR_W-1:0]                r_tail;
  logic [CNT_W-1:0]                r_count;
  logic [DEPTH-1:0]                r_valid;
  logic [DEPTH-1:0][ADDR_BITS-1:0] r_addr;
  logic [31:0]                     r_data [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_drain;
  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // A load always wins the port; a store alongside it is refused.
  assign w_enq   = st_req && !ld_req && !w_full;
  assign w_drain = !w_empty && !ld_req && (!st_req || w_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_enq) begin
        r_tail          <= r_tail + 1'b1;
        r_valid[r_tail] <= 1'b1;
      end
      if (w_drain) begin
        r_head          <= r_head + 1'b1;
        r_valid[r_head] <= 1'b0;
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= addr[ADDR_BITS-1:0];
      r_data[r_tail] <= wr_data;
    end
  end

  store_buffer_match #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_match (
    .i_ent_addr (r_addr),
    .i_valid    (r_valid),
    .i_tail     (r_tail),
    .i_ld_addr  (addr[ADDR_BITS-1:0]),
    .o_hit      (w_hit),
    .o_idx      (w_hit_idx)
  );

  always_comb begin
    stall       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    ld_data     = '0;
    if (!rst) begin
      stall = st_req && (w_full || ld_req);
      if (w_drain) begin
        mem_write   = 1'b1;
        mem_address = 32'(r_addr[r_head]);
        mem_data    = r_data[r_head];
      end else if (ld_req && !w_hit) begin
        mem_read    = 1'b1;
        mem_address = addr;
      end
      if (ld_req) begin
        ld_data = w_hit ? r_data[w_hit_idx] : mem_out;
      end
    end
  end

  assign empty = w_empty;
  assign count = r_count;

endmodule

`default_nettype wire
